codec_init_seq: RTL and testbench
=================================

Name: codec_init_seq

Overview:
- Power-up register-configuration sequencer for the audio codec. It walks a fixed table of 16-bit register words and issues one I2C write per word.
- Sits directly upstream of the I2C master FSM and drives its command/handshake inputs.
- Runs on the 250 kHz slow clock domain, alongside the I2S controller, which must not carry valid audio until `done` is high.
- Exposes progress and state codes for seven-segment debug.

Parameters:
- NUM_REGS, 10, number of register words in the table (1..15).
- DEV_ADDR, 7'h1A, 7-bit I2C device address of the codec.
- STARTUP_DELAY, 250, slow-clock cycles to wait after sequence start before the first write (1 ms at 250 kHz); minimum 1.
- RETRY_GAP, 25, idle cycles between a NACKed write and its retry; minimum 1.
- MAX_RETRIES, 3, retries allowed per register word before the block declares an error.
- AUTO_START, 1, when 1 the sequence starts automatically after reset release.

Ports:
- clk, input, 1, slow clock.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to (re)run the sequence.
- i2c_busy, input, 1, I2C master transaction in progress.
- i2c_done, input, 1, one-cycle pulse at the end of a transaction.
- i2c_ack_err, input, 1, valid with i2c_done; 1 means a NACK was received.
- i2c_start, output, 1, one-cycle command pulse to the I2C master.
- i2c_dev_addr, output, 7, always DEV_ADDR.
- i2c_byte0, output, 8, {reg_addr[6:0], reg_data[8]}.
- i2c_byte1, output, 8, reg_data[7:0].
- busy, output, 1, sequence in progress.
- done, output, 1, sticky; all words acknowledged.
- error, output, 1, sticky; retries exhausted.
- reg_index, output, 4, index of the current word.
- state_info, output, 4, encoded FSM state for the seven-segment display.

Behaviour:
- Reset (reset=0, asynchronous) clears i2c_start, busy, done, error, reg_index, i2c_byte0, i2c_byte1, the retry counter and the delay counter. The state goes to IDLE. reset=0 mid-transaction aborts immediately; the I2C master is reset by the same signal.
- State encoding for state_info: IDLE=0, DELAY=1, LOAD=2, ISSUE=3, WAIT=4, RETRY=5, DONE=6, ERROR=7.
- IDLE:
  - The first cycle after reset release goes to DELAY if AUTO_START=1.
  - Otherwise start=1 goes to DELAY.
  - Entering DELAY loads the delay counter with STARTUP_DELAY-1, clears reg_index and the retry counter, and sets busy=1.
- DELAY: decrement each cycle; at 0 go to LOAD.
- LOAD: register the table word for reg_index into i2c_byte0/i2c_byte1; go to ISSUE.
- ISSUE:
  - If i2c_busy=0, assert i2c_start for exactly this cycle and go to WAIT.
  - Otherwise hold in ISSUE with i2c_start=0.
  - Bytes are stable from LOAD until WAIT exits.
- WAIT: ignore all inputs except i2c_done. On i2c_done=1:
  - i2c_ack_err=0 and reg_index=NUM_REGS-1: go to DONE; set done=1, busy=0.
  - i2c_ack_err=0 otherwise: reg_index+1, retry counter cleared, go to LOAD.
  - i2c_ack_err=1 and retry counter < MAX_RETRIES: increment the counter, load the delay counter with RETRY_GAP-1, go to RETRY.
  - i2c_ack_err=1 and retry counter = MAX_RETRIES: go to ERROR; set error=1, busy=0. reg_index holds the failing word.
- RETRY: decrement the counter; at 0 go to ISSUE with the same bytes; reg_index is unchanged.
- DONE / ERROR:
  - Hold the sticky flag.
  - start=1 clears done and error and re-enters DELAY exactly as from IDLE.
- start is ignored in DELAY, LOAD, ISSUE, WAIT and RETRY.
- Latency from entering LOAD to the i2c_start pulse is 2 cycles when the master is idle.
- Total writes issued in an error-free run: NUM_REGS; each word is issued at most 1+MAX_RETRIES times.
- i2c_done outside WAIT is ignored.

Decomposition:
- Shared package codec_pkg holds:
  - the state enum/localparams with the state_info codes;
  - the WM8731-style register address constants (LINVOL, RINVOL, LHPOUT, RHPOUT, APANA, DPATH, PWRDN, IFACE, SRATE, ACTIVE, RESET);
  - the 16-bit word format {addr[6:0], data[8:0]}.
- Sub-module codec_reg_rom is a combinational 4-bit index to 16-bit word table of NUM_REGS entries:
  - RESET first, ACTIVE=1 last;
  - IFACE set to I2S, 16-bit, slave mode;
  - out-of-range indices return 16'h0000.

Test Plan:
- Use a bench I2C master model with 3-cycle busy and a done pulse, AUTO_START=1, STARTUP_DELAY=4, NUM_REGS=10.
  - Release reset -> first i2c_start at cycle 6 (4 DELAY cycles + LOAD + ISSUE).
  - Exactly 10 pulses with bytes matching the ROM; done=1, busy=0 after the 10th ack.
- NACK word 3 twice, then ack (RETRY_GAP=2) -> word 3 is issued 3 times with identical bytes, each retry 2 idle cycles after done; reg_index=3 throughout; sequence completes with done=1.
- NACK word 5 on every attempt, MAX_RETRIES=3 -> 4 attempts, then error=1, done=0, reg_index=5, state_info=7, no further i2c_start.
- Hold i2c_busy=1 for 10 cycles while in ISSUE -> i2c_start stays 0; a single pulse occurs on the first cycle after busy falls.
- Pulse start during WAIT, then again in DONE -> first is ignored; second clears done, busy rises next cycle, and all 10 words are reissued.
- Assert reset=0 asynchronously mid-WAIT on word 7 -> all outputs are 0 within the same cycle; after release the sequence restarts from word 0.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared definitions for the codec power-up sequencer: state codes,
// WM8731-style register addresses and the 16-bit control word format.
package codec_pkg;

  // State codes double as the seven-segment debug value.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_DELAY = 4'd1,
    ST_LOAD  = 4'd2,
    ST_ISSUE = 4'd3,
    ST_WAIT  = 4'd4,
    ST_RETRY = 4'd5,
    ST_DONE  = 4'd6,
    ST_ERROR = 4'd7
  } seq_state_e;

  // Codec register addresses (7-bit).
  localparam logic [6:0] REG_LINVOL = 7'h00;
  localparam logic [6:0] REG_RINVOL = 7'h01;
  localparam logic [6:0] REG_LHPOUT = 7'h02;
  localparam logic [6:0] REG_RHPOUT = 7'h03;
  localparam logic [6:0] REG_APANA  = 7'h04;
  localparam logic [6:0] REG_DPATH  = 7'h05;
  localparam logic [6:0] REG_PWRDN  = 7'h06;
  localparam logic [6:0] REG_IFACE  = 7'h07;
  localparam logic [6:0] REG_SRATE  = 7'h08;
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  // One control word as sent on the wire: {addr[6:0], data[8:0]}.
  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } reg_word_t;

  function automatic reg_word_t make_word(input logic [6:0] addr, input logic [8:0] data);
    reg_word_t w;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/codec_reg_rom.sv
// Combinational configuration table: index -> control word.
// RESET is always first and ACTIVE=1 is always the last valid entry.
module codec_reg_rom
  import codec_pkg::*;
#(
  parameter int NUM_REGS = 10
) (
  input  logic [3:0] index,
  output reg_word_t  word
);

  // Table lookup; anything past the last entry reads as zero.
  always_comb begin
    word = '0;
    if (index == 4'(NUM_REGS - 1)) begin
      word = make_word(REG_ACTIVE, 9'h001);
    end else if (int'(index) < NUM_REGS - 1) begin
      case (index)
        4'd0:    word = make_word(REG_RESET,  9'h000);
        4'd1:    word = make_word(REG_LINVOL, 9'h017);  // 0 dB, unmuted
        4'd2:    word = make_word(REG_RINVOL, 9'h017);
        4'd3:    word = make_word(REG_LHPOUT, 9'h079);  // 0 dB headphone
        4'd4:    word = make_word(REG_RHPOUT, 9'h079);
        4'd5:    word = make_word(REG_APANA,  9'h012);  // DAC selected, mic muted
        4'd6:    word = make_word(REG_DPATH,  9'h000);  // DAC soft-mute off
        4'd7:    word = make_word(REG_PWRDN,  9'h000);  // everything powered
        4'd8:    word = make_word(REG_IFACE,  9'h002);  // I2S, 16-bit, slave
        // Longer tables pad with a harmless normal-mode sample-rate write.
        default: word = make_word(REG_SRATE,  9'h000);
      endcase
    end
  end

endmodule

// File: rtl/codec_init_seq.sv
// Codec power-up sequencer: walks the register table and issues one I2C
// write per word, retrying NACKed writes a bounded number of times.
module codec_init_seq
  import codec_pkg::*;
#(
  parameter int         NUM_REGS      = 10,
  parameter logic [6:0] DEV_ADDR      = 7'h1A,
  parameter int         STARTUP_DELAY = 250,
  parameter int         RETRY_GAP     = 25,
  parameter int         MAX_RETRIES   = 3,
  parameter bit         AUTO_START    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_ack_err,
  output logic       i2c_start,
  output logic [6:0] i2c_dev_addr,
  output logic [7:0] i2c_byte0,
  output logic [7:0] i2c_byte1,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] reg_index,
  output logic [3:0] state_info
);

  // One down-counter serves both the startup wait and the retry gap.
  localparam int DLY_MAX = (STARTUP_DELAY > RETRY_GAP) ? STARTUP_DELAY : RETRY_GAP;
  localparam int DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX);
  localparam int RTY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  seq_state_e       state_q, state_d;
  logic [DLY_W-1:0] delay_q, delay_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [3:0]       reg_index_q, reg_index_d;
  logic [7:0]       byte0_q, byte0_d;
  logic [7:0]       byte1_q, byte1_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  reg_word_t        rom_word;

  codec_reg_rom #(
    .NUM_REGS(NUM_REGS)
  ) u_rom (
    .index(reg_index_q),
    .word (rom_word)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    retry_d     = retry_q;
    reg_index_d = reg_index_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      ST_IDLE: begin
        // Reset is the only way into IDLE, so auto-start fires on the
        // first clock after release.
        if (AUTO_START || start) begin
          state_d     = ST_DELAY;
          delay_d     = DLY_W'(STARTUP_DELAY - 1);
          reg_index_d = 4'd0;
          retry_d     = '0;
          busy_d      = 1'b1;
        end
      end
      ST_DELAY: begin
        if (delay_q == '0) state_d = ST_LOAD;
        else               delay_d = delay_q - 1'b1;
      end
      ST_LOAD: begin
        byte0_d = {rom_word.addr, rom_word.data[8]};
        byte1_d = rom_word.data[7:0];
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Registered pulse: it is high during the first WAIT cycle.
        if (!i2c_busy) begin
          start_d = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i2c_done) begin
          if (!i2c_ack_err) begin
            if (reg_index_q == 4'(NUM_REGS - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              reg_index_d = reg_index_q + 4'd1;
              retry_d     = '0;
              state_d     = ST_LOAD;
            end
          end else if (retry_q < RTY_W'(MAX_RETRIES)) begin
            retry_d = retry_q + 1'b1;
            delay_d = DLY_W'(RETRY_GAP - 1);
            state_d = ST_RETRY;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      ST_RETRY: begin
        // Bytes are left untouched so the retry resends the same word.
        if (delay_q == '0) state_d = ST_ISSUE;
        else               delay_d = delay_q - 1'b1;
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d     = ST_DELAY;
          delay_d     = DLY_W'(STARTUP_DELAY - 1);
          reg_index_d = 4'd0;
          retry_d     = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any sequence immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      delay_q     <= '0;
      retry_q     <= '0;
      reg_index_q <= 4'd0;
      byte0_q     <= 8'd0;
      byte1_q     <= 8'd0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      retry_q     <= retry_d;
      reg_index_q <= reg_index_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign i2c_start    = start_q;
  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_byte0    = byte0_q;
  assign i2c_byte1    = byte1_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign reg_index    = reg_index_q;
  assign state_info   = state_q;

endmodule

// File: tb/tb_codec_init_seq.sv
// Bench for codec_init_seq: scripted I2C master, cycle-level reference
// model with one compare process, and directed literal checks per scenario.
module tb_codec_init_seq;

  localparam int NUM_REGS      = 10;
  localparam int STARTUP_DELAY = 4;
  localparam int RETRY_GAP     = 2;
  localparam int MAX_RETRIES   = 3;
  localparam bit AUTO_START    = 1'b1;
  localparam int HOLD          = 12;

  // Expected control words, hand-assembled as {addr[6:0], data[8:0]}.
  logic [15:0] rom_exp [NUM_REGS] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                      16'h0812, 16'h0A00, 16'h0C00, 16'h0E02, 16'h1201};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       i2c_busy = 1'b0, i2c_done = 1'b0, i2c_ack_err = 1'b0;
  logic       i2c_start;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_byte0, i2c_byte1;
  logic       busy, done, error;
  logic [3:0] reg_index, state_info;

  codec_init_seq #(
    .NUM_REGS(NUM_REGS), .DEV_ADDR(7'h1A), .STARTUP_DELAY(STARTUP_DELAY),
    .RETRY_GAP(RETRY_GAP), .MAX_RETRIES(MAX_RETRIES), .AUTO_START(AUTO_START)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .i2c_busy(i2c_busy), .i2c_done(i2c_done),
    .i2c_ack_err(i2c_ack_err), .i2c_start(i2c_start), .i2c_dev_addr(i2c_dev_addr),
    .i2c_byte0(i2c_byte0), .i2c_byte1(i2c_byte1), .busy(busy), .done(done), .error(error),
    .reg_index(reg_index), .state_info(state_info)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scripted I2C master ----------------
  int nack_word = -1, nack_times = 0, hold_word = -1;
  int m_word = 0, m_att = 0, mcnt = 0, hold = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mcnt = 0; hold = 0; m_word = 0; m_att = 0;
        i2c_busy = 1'b0; i2c_done = 1'b0; i2c_ack_err = 1'b0;
      end else begin
        i2c_done = 1'b0;
        i2c_ack_err = 1'b0;
        if (hold > 0) hold--;
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) begin
            i2c_done = 1'b1;
            if (m_word == nack_word && m_att < nack_times) begin
              i2c_ack_err = 1'b1;
              m_att++;
            end else begin
              if (m_word == hold_word) hold = HOLD;
              m_word++;
              m_att = 0;
            end
          end
        end else if (i2c_start) begin
          mcnt = 3;
        end
        i2c_busy = (mcnt > 0) || (hold > 0);
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  int cyc = 0, exp_word = 0, exp_att = 0, pulse_at = -1, run_start = 0;
  bit m_idle = 1'b1, running = 1'b0, m_done = 1'b0, m_err = 1'b0, in_flight = 1'b0;
  int dut_pulses = 0, first_pulse = -1, last_done = 0;
  int word_att [16];
  int gap_w [16];

  initial begin
    logic s_rst, s_start, s_busy, s_done, s_err, exp_pulse;
    logic [15:0] w;
    forever begin
      @(posedge clk);
      s_rst = reset; s_start = start; s_busy = i2c_busy; s_done = i2c_done; s_err = i2c_ack_err;
      #1;
      cyc++;
      exp_pulse = 1'b0;
      if (!s_rst) begin
        m_idle = 1'b1; running = 1'b0; m_done = 1'b0; m_err = 1'b0; in_flight = 1'b0;
        exp_word = 0; exp_att = 0; pulse_at = -1;
      end else if (in_flight) begin
        if (s_done) begin
          in_flight = 1'b0;
          last_done = cyc;
          if (!s_err) begin
            if (exp_word == NUM_REGS - 1) begin running = 1'b0; m_done = 1'b1; end
            else begin exp_word++; exp_att = 0; pulse_at = cyc + 2; end
          end else if (exp_att < MAX_RETRIES) begin
            exp_att++;
            pulse_at = cyc + RETRY_GAP + 1;
          end else begin
            running = 1'b0; m_err = 1'b1;
          end
        end
      end else if (running) begin
        if (pulse_at >= 0 && cyc >= pulse_at && !s_busy) begin
          exp_pulse = 1'b1; in_flight = 1'b1; pulse_at = -1;
        end
      end else if ((m_idle && (AUTO_START || s_start)) || ((m_done || m_err) && s_start)) begin
        m_idle = 1'b0; running = 1'b1; m_done = 1'b0; m_err = 1'b0;
        exp_word = 0; exp_att = 0; pulse_at = cyc + STARTUP_DELAY + 2;
        run_start = cyc; dut_pulses = 0; first_pulse = -1;
        for (int i = 0; i < 16; i++) begin word_att[i] = 0; gap_w[i] = 0; end
      end

      // Observe what the DUT actually did, for the literal checks.
      if (i2c_start === 1'b1) begin
        dut_pulses++;
        word_att[exp_word]++;
        gap_w[exp_word] = cyc - last_done;
        if (first_pulse < 0) first_pulse = cyc - run_start;
      end

      chk("i2c_start", {31'd0, i2c_start}, {31'd0, exp_pulse});
      chk("busy", {31'd0, busy}, {31'd0, running});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("error", {31'd0, error}, {31'd0, m_err});
      chk("dev_addr", {25'd0, i2c_dev_addr}, 32'h1A);
      chk("reg_index", {28'd0, reg_index}, exp_word);
      if (in_flight || (running && pulse_at >= 0 && exp_att > 0)) begin
        w = rom_exp[exp_word];
        chk("byte0", {24'd0, i2c_byte0}, {24'd0, w[15:8]});
        chk("byte1", {24'd0, i2c_byte1}, {24'd0, w[7:0]});
      end
      if (!s_rst)         chk("state_info", {28'd0, state_info}, 32'd0);
      else if (m_err)     chk("state_info", {28'd0, state_info}, 32'd7);
      else if (m_done)    chk("state_info", {28'd0, state_info}, 32'd6);
      else if (in_flight) chk("state_info", {28'd0, state_info}, 32'd4);
    end
  end

  // ---------------- stimulus ----------------
  function automatic bit cond_met(input int what, input int k);
    case (what)
      0:       return m_done;
      1:       return m_err;
      default: return in_flight && exp_word == k;
    endcase
  endfunction

  task automatic wait_for(input int what, input int k, input string name);
    int n = 0;
    while (!cond_met(what, k) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!cond_met(what, k)) begin
      fails++;
      $display("FAIL %s: timed out after %0d cycles", name, n);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Run 1: auto start after reset, clean run.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_for(0, 0, "run1_done");
    chk("run1_first_start_cycle", first_pulse, 6);
    chk("run1_pulses", dut_pulses, 10);
    chk("run1_last_word_once", word_att[9], 1);

    // Run 2: restart from DONE; word 3 NACKed twice; start during WAIT ignored.
    nack_word = 3; nack_times = 2; m_word = 0; m_att = 0;
    pulse_start();
    wait_for(2, 1, "run2_wait_word1");
    pulse_start();
    wait_for(0, 0, "run2_done");
    chk("run2_pulses", dut_pulses, 12);
    chk("run2_word3_attempts", word_att[3], 3);
    // done sampled at E -> RETRY x2, ISSUE -> pulse registered at E+3
    chk("run2_retry_gap", gap_w[3], 3);
    // ack at E -> LOAD, ISSUE -> pulse at E+2
    chk("run2_ack_gap", gap_w[4], 2);

    // Run 3: master holds busy while the sequencer sits in ISSUE for word 1.
    nack_word = -1; hold_word = 0; m_word = 0; m_att = 0;
    pulse_start();
    wait_for(0, 0, "run3_done");
    chk("run3_busy_hold_gap", gap_w[1], HOLD);
    chk("run3_pulses", dut_pulses, 10);

    // Run 4: word 5 always NACKed -> error after 4 attempts.
    hold_word = -1; nack_word = 5; nack_times = 99; m_word = 0; m_att = 0;
    pulse_start();
    wait_for(1, 0, "run4_error");
    repeat (30) @(negedge clk);
    chk("run4_error", {31'd0, error}, 32'd1);
    chk("run4_done", {31'd0, done}, 32'd0);
    chk("run4_reg_index", {28'd0, reg_index}, 32'd5);
    chk("run4_state_info", {28'd0, state_info}, 32'd7);
    chk("run4_pulses", dut_pulses, 9);
    chk("run4_word5_attempts", word_att[5], 4);

    // Run 5: restart from ERROR, async reset while waiting on word 7.
    nack_word = -1; m_word = 0; m_att = 0;
    pulse_start();
    wait_for(2, 7, "run5_wait_word7");
    #2;
    reset = 1'b0;
    #1;
    chk("async_i2c_start", {31'd0, i2c_start}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_error", {31'd0, error}, 32'd0);
    chk("async_reg_index", {28'd0, reg_index}, 32'd0);
    chk("async_byte0", {24'd0, i2c_byte0}, 32'd0);
    chk("async_byte1", {24'd0, i2c_byte1}, 32'd0);
    chk("async_state_info", {28'd0, state_info}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Run 6: auto restart from word 0 after reset release.
    wait_for(0, 0, "run6_done");
    chk("run6_first_start_cycle", first_pulse, 6);
    chk("run6_pulses", dut_pulses, 10);
    chk("run6_word0_once", word_att[0], 1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
